// File: rtl/accel_smoother.sv
// Sampled 2^LOG2_TAPS moving average with decaying peak-hold, driving a 16-LED bar.
// Outputs register one edge after the sampling tick; enable=0 freezes every piece of state.
module accel_smoother #(
    parameter int SAMPLE_DIV = 1_000_000,
    parameter int LOG2_TAPS  = 3,
    parameter int PEAK_HOLD  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  accel_in,
    input  logic        enable,
    output logic [8:0]  avg_out,
    output logic        avg_valid,
    output logic [8:0]  peak_out,
    output logic [15:0] led_bar
);

    localparam int TAPS = 1 << LOG2_TAPS;
    localparam int CW   = $clog2(SAMPLE_DIV);
    localparam int SW   = 9 + LOG2_TAPS;
    localparam int HW   = $clog2(PEAK_HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    typedef enum logic {UNPRIMED, RUN} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic                  tick;
    logic                  prime;
    logic [SW-1:0]         sum;
    logic [LOG2_TAPS-1:0]  wr_ptr;
    logic [8:0]            taps_mem [TAPS];
    logic                  pend;
    logic [HW-1:0]         hold_cnt, hold_next;
    logic [8:0]            avg_new, peak_next;

    assign tick    = enable && (cnt == LAST);
    assign avg_new = sum[SW-1:LOG2_TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= UNPRIMED;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        prime      = 1'b0;
        if (tick && state == UNPRIMED) begin
            prime      = 1'b1;
            state_next = RUN;
        end
    end

    // The first sample after reset floods the whole window so the average starts settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum    <= '0;
            wr_ptr <= '0;
        end else if (tick) begin
            if (prime) begin
                sum    <= SW'(accel_in) << LOG2_TAPS;
                wr_ptr <= '0;
            end else begin
                sum    <= sum + SW'(accel_in) - SW'(taps_mem[wr_ptr]);
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tick) begin
            if (prime) begin
                for (int i = 0; i < TAPS; i++)
                    taps_mem[i] <= accel_in;
            end else begin
                taps_mem[wr_ptr] <= accel_in;
            end
        end
    end

    always_comb begin
        peak_next = peak_out;
        hold_next = hold_cnt;
        if (avg_new >= peak_out) begin
            peak_next = avg_new;
            hold_next = '0;
        end else if (hold_cnt < HW'(PEAK_HOLD)) begin
            hold_next = hold_cnt + HW'(1);
        end else begin
            // avg_new < peak_out here, so peak_out >= 1 and the decrement cannot wrap.
            peak_next = ((peak_out - 9'd1) > avg_new) ? (peak_out - 9'd1) : avg_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            avg_valid <= 1'b0;
            avg_out   <= '0;
            peak_out  <= '0;
            hold_cnt  <= '0;
            led_bar   <= '0;
        end else if (enable) begin
            pend      <= tick;
            avg_valid <= pend;
            if (pend) begin
                avg_out  <= avg_new;
                peak_out <= peak_next;
                hold_cnt <= hold_next;
                led_bar  <= (16'd1 << avg_new[8:5]) | (16'd1 << peak_next[8:5]);
            end
        end else begin
            avg_valid <= 1'b0;
        end
    end

endmodule

// File: doc/accel_smoother.md
# accel_smoother

Sampled moving-average filter with peak-hold for the 9-bit accelerometer axis output. Sits between the accelerometer interface and the LED bar display, replacing the raw combinational LED decode with a stable, low-jitter bar. Samples the free-running axis value at a fixed rate, averages the last 2^LOG2_TAPS samples and tracks a decaying peak. Drives both to a 16-LED bar.

## Interface
- SAMPLE_DIV, 1_000_000, clocks between samples (≥2)
- LOG2_TAPS, 3, log2 of averaging window depth (window = 8)
- PEAK_HOLD, 50, averaged updates the peak holds before it starts decaying (≥1)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock domain
- accel_in  in  9  raw axis value, unsigned 0x000–0x1FF, treated as quasi-static
- enable  in  1  1 = sampling runs; 0 = freeze divider and all state
- avg_out  out  9  window average
- avg_valid  out  1  one-cycle pulse when avg_out, peak_out, led_bar update
- peak_out  out  9  held/decaying maximum of avg_out
- led_bar  out  16  (1 << avg_out[8:5]) | (1 << peak_out[8:5])

## Operation
- Divider: counter 0..SAMPLE_DIV-1, advances only when enable=1, wraps to 0. tick = enable && cnt==SAMPLE_DIV-1.
- States: UNPRIMED (after reset) and RUN.
- UNPRIMED, on tick: write accel_in into all 2^LOG2_TAPS buffer entries; sum <= accel_in << LOG2_TAPS; wr_ptr <= 0; go to RUN. Buffer contents at reset are don't-care.
- RUN, on tick: sum <= sum + accel_in − buf[wr_ptr]; buf[wr_ptr] <= accel_in; wr_ptr <= wr_ptr+1 mod 2^LOG2_TAPS.
- sum width is 9+LOG2_TAPS bits (12 by default). It cannot overflow. avg_out = sum >> LOG2_TAPS, truncating.
- Peak, evaluated with each new average A:
  - If A ≥ peak: peak <= A and hold_cnt <= 0.
  - Else if hold_cnt < PEAK_HOLD: hold_cnt++.
  - Else: peak <= max(A, peak−1).
- led_bar: when avg and peak fall in the same 32-wide bucket, exactly one bit is set.
- enable=0: the divider, buffer, sum, peak and outputs all hold. avg_valid stays 0. Resuming continues from the held count.

## Timing
- Reset (rst_n=0, no clock needed): avg_out=0, avg_valid=0, peak_out=0, led_bar=0, cnt=0, hold_cnt=0, state UNPRIMED.
- Latency:
  - accel_in is captured on edge E0, where tick=1. sum and buffer update at E0.
  - avg_out, peak_out, led_bar and avg_valid=1 are registered at E1.
  - avg_valid drops at E2.
- First avg_valid after reset release with enable held high: edge SAMPLE_DIV+1 counting from the first enabled edge.
- Outputs change only on avg_valid edges. Between updates they are stable.
- Reset asserted mid-operation clears everything asynchronously. The next tick after release re-primes.
- Peak decay rate is at most 1 LSB per averaged update.

## Test plan
- Prime, using SAMPLE_DIV=4 and PEAK_HOLD=4: reset, enable=1, accel_in=0x100. The first avg_valid arrives on the 5th edge, with avg_out=0x100, peak_out=0x100 and led_bar=0x0100.
- Step response: prime with 0x000, then hold 0x1F8.
  - The next 8 averages are 0x03F, 0x07E, 0x0BD, 0x0FC, 0x13B, 0x17A, 0x1B9, 0x1F8, after which avg_out stays at 0x1F8.
  - peak_out equals avg_out each step.
  - The final led_bar is 0x8000.
- Peak hold/decay: after the steady 0x1F8 state, drive 0x1F0.
  - avg_out converges to 0x1F0 over 8 updates.
  - peak_out stays 0x1F8 for 4 updates, then decrements 0x1F7, 0x1F6, … and never goes below avg_out.
  - It ends at 0x1F0.
- Enable freeze: drop enable for 20 cycles mid-divider. There is no avg_valid and the outputs are unchanged. After enable returns, the next avg_valid arrives after the remaining count plus 1 edge.
- Async reset mid-run: pulse rst_n low between clock edges.
  - All outputs read 0 before the next edge.
  - After release with accel_in=0x0A0, the first average is 0x0A0 (re-prime) and led_bar=0x0020.
- Full scale: hold accel_in at 0x1FF. avg_out=0x1FF, peak_out=0x1FF and led_bar=0x8000, with no wrap.
